// File: rtl/mmu_walk_arbiter_pkg.sv
// mmu_walk_arbiter_pkg: shared widths and the arbiter state type for the walker arbiter
package mmu_walk_arbiter_pkg;
  localparam int PPN_W = 20;
  localparam int VA_W = 32;
  typedef enum logic [1:0] {IDLE, WALK, ABORT} mmu_arb_state_t;
endpackage

// File: rtl/mmu_walk_arbiter_if.sv
// mmu_walk_arbiter_if: TLB requester bundle (req_*) and walker bundle (walk_*); master = arbiter, slave = TLBs/walker
interface mmu_walk_arbiter_if #(parameter int NUM_PORTS = 2) ();
  import mmu_walk_arbiter_pkg::*;
  logic [NUM_PORTS-1:0] req_request, req_execute, req_rnw, req_write_entry, req_is_fault;
  logic [NUM_PORTS-1:0][VA_W-1:0] req_virtual_address;
  logic [PPN_W-1:0] req_upper_physical_address, walk_upper_physical_address;
  logic walk_request, walk_execute, walk_rnw, walk_abort, walk_write_entry, walk_is_fault;
  logic [VA_W-1:0] walk_virtual_address;
  modport master (
    input req_request, req_virtual_address, req_execute, req_rnw,
    input walk_write_entry, walk_is_fault, walk_upper_physical_address,
    output req_write_entry, req_is_fault, req_upper_physical_address,
    output walk_request, walk_virtual_address, walk_execute, walk_rnw, walk_abort
  );
  modport slave (
    output req_request, req_virtual_address, req_execute, req_rnw,
    output walk_write_entry, walk_is_fault, walk_upper_physical_address,
    input req_write_entry, req_is_fault, req_upper_physical_address,
    input walk_request, walk_virtual_address, walk_execute, walk_rnw, walk_abort
  );
endinterface

// File: rtl/rr_priority_select.sv
// rr_priority_select: combinational round-robin pick; in req/mask/ptr, out one-hot grant and its index
module rr_priority_select #(
  parameter int N = 2,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);
  logic [W-1:0] p;
  always_comb begin
    grant = '0;
    idx = '0;
    p = '0;
    for (int i = N - 1; i >= 0; i--) begin
      p = W'((int'(ptr) + i) % N);
      if (req[p] && mask[p]) begin
        grant = '0;
        grant[p] = 1'b1;
        idx = p;
      end
    end
  end
endmodule

// File: rtl/mmu_walk_arbiter.sv
// mmu_walk_arbiter: round-robin share of one page-table walker among NUM_PORTS TLBs; ports clk, rst, tlb_flush, bus (master)
module mmu_walk_arbiter import mmu_walk_arbiter_pkg::*; #(
  parameter int NUM_PORTS = 2
) (
  input logic clk,
  input logic rst,
  input logic tlb_flush,
  mmu_walk_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_PORTS);
  mmu_arb_state_t state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, gnt_idx;
  logic [VA_W-1:0] va_q, va_d;
  logic exec_q, exec_d, rnw_q, rnw_d;
  logic [NUM_PORTS-1:0] done_q, done_d, gnt;
  logic owner_live, complete, grant_ok;
  rr_priority_select #(.N(NUM_PORTS)) u_sel (
    .req(bus.req_request),
    .mask(~done_q),
    .ptr(rr_ptr_q),
    .grant(gnt),
    .idx(gnt_idx)
  );
  always_comb begin
    owner_live = bus.req_request[owner_q] && !tlb_flush;
    complete = state_q == WALK && owner_live && (bus.walk_write_entry || bus.walk_is_fault);
    done_d = complete ? NUM_PORTS'(1) << owner_q : '0;
    grant_ok = state_q == IDLE && !tlb_flush && |gnt;
    state_d = state_q == IDLE ? (grant_ok ? WALK : IDLE) :
              state_q == WALK ? (!owner_live ? ABORT : complete ? IDLE : WALK) : IDLE;
    owner_d = grant_ok ? gnt_idx : owner_q;
    rr_ptr_d = grant_ok ? (gnt_idx == IW'(NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1) : rr_ptr_q;
    va_d = grant_ok ? bus.req_virtual_address[gnt_idx] : va_q;
    exec_d = grant_ok ? bus.req_execute[gnt_idx] : exec_q;
    rnw_d = grant_ok ? bus.req_rnw[gnt_idx] : rnw_q;
    bus.req_write_entry = bus.walk_write_entry ? done_d : '0;
    bus.req_is_fault = bus.walk_is_fault ? done_d : '0;
    bus.req_upper_physical_address = bus.walk_upper_physical_address;
    bus.walk_request = state_q == WALK;
    bus.walk_abort = state_q == ABORT;
    bus.walk_virtual_address = va_q;
    bus.walk_execute = exec_q;
    bus.walk_rnw = rnw_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      owner_q <= '0;
      va_q <= '0;
      exec_q <= 1'b0;
      rnw_q <= 1'b0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q <= owner_d;
      va_q <= va_d;
      exec_q <= exec_d;
      rnw_q <= rnw_d;
      done_q <= done_d;
    end
  end
endmodule
